mul_req_arbiter: RTL

- Shares the single multi-cycle multiplier core between the two host front ends of the multiplier tile: the UART RX path, whose 16-bit operand word is assembled from two bytes, and the SPI slave path, which delivers 16-bit frames.
- Round-robin arbitration; exactly one multiply in flight at a time.
- Returns each result tagged with its originating requester, so the matching front end transmits it.
- Includes a watchdog so a hung multiplier cannot lock either interface.

---
 rtl/mul_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/mul_req_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// ============================================================================
// Module   : mul_arb_pkg
// Brief    : Shared types and constants for the multiplier request arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic TAG_UART = 1'b0;
  localparam logic TAG_SPI  = 1'b1;

  // Sliced down to the result width at the point of use.
  localparam logic [63:0] ERR_RESULT = '1;

endpackage : mul_arb_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin picker; grant is one-hot or zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import mul_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie, favour whichever side was not served last.
        2'b11:   grant = (last == TAG_SPI) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/mul_req_arbiter.sv
// ============================================================================
// Module   : mul_req_arbiter
// Brief    : Shares one multi-cycle multiplier between UART and SPI front ends.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_req_arbiter
  import mul_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int DW          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_valid,
  input  logic [DW-1:0]   uart_data,
  output logic            uart_ready,
  input  logic            spi_valid,
  input  logic [DW-1:0]   spi_data,
  output logic            spi_ready,
  output logic            mul_start,
  output logic [DW/2-1:0] mul_a,
  output logic [DW/2-1:0] mul_b,
  input  logic            mul_busy,
  input  logic            mul_done,
  input  logic [DW-1:0]   mul_result,
  output logic            res_valid,
  output logic [DW-1:0]   res_data,
  output logic            res_tag,
  output logic            res_err,
  input  logic            res_ready,
  output logic [7:0]      cnt_uart,
  output logic [7:0]      cnt_spi
);

  localparam int HW   = DW / 2;
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_t      r_state;
  arb_state_t      w_state_next;
  logic            r_last_grant;
  logic [HW-1:0]   r_a;
  logic [HW-1:0]   r_b;
  logic            r_tag;
  logic [DW-1:0]   r_res;
  logic            r_err;
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_inc;
  logic            w_timeout;
  logic [7:0]      r_cnt_uart;
  logic [7:0]      r_cnt_spi;
  logic [1:0]      w_grant;
  logic [DW-1:0]   w_sel_data;
  logic            w_issue_go;

  rr_arb2 u_rr_arb2 (
    .req    ({spi_valid, uart_valid}),
    .last   (r_last_grant),
    .enable (r_state == IDLE),
    .grant  (w_grant)
  );

  assign uart_ready = w_grant[0];
  assign spi_ready  = w_grant[1];
  assign w_sel_data = w_grant[1] ? spi_data : uart_data;
  assign w_issue_go = (r_state == ISSUE) && !mul_busy;

  // The abort fires when the incremented count lands on TIMEOUT_CYC-1, so
  // res_valid rises exactly TIMEOUT_CYC cycles after the start pulse.
  assign w_wd_inc  = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
  assign w_timeout = (w_wd_inc == WD_LAST);

  always_comb begin
    w_state_next = r_state;
    mul_start    = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) w_state_next = ISSUE;
      end
      ISSUE: begin
        if (!mul_busy) begin
          mul_start    = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (mul_done || w_timeout) w_state_next = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= TAG_SPI;
      r_a          <= '0;
      r_b          <= '0;
      r_tag        <= TAG_UART;
      r_res        <= '0;
      r_err        <= 1'b0;
      r_wd         <= '0;
      r_cnt_uart   <= 8'd0;
      r_cnt_spi    <= 8'd0;
    end else begin
      if ((r_state == IDLE) && (|w_grant)) begin
        r_a          <= w_sel_data[DW-1:HW];
        r_b          <= w_sel_data[HW-1:0];
        r_tag        <= w_grant[1];
        r_last_grant <= w_grant[1];
      end
      if (w_issue_go) begin
        r_wd <= '0;
      end
      if (r_state == WAIT) begin
        r_wd <= w_wd_inc;
        // A completion in the same cycle as the abort still wins.
        if (mul_done) begin
          r_res <= mul_result;
          r_err <= 1'b0;
        end else if (w_timeout) begin
          r_res <= ERR_RESULT[DW-1:0];
          r_err <= 1'b1;
        end
      end
      if ((r_state == RESP) && res_ready) begin
        if (r_tag == TAG_SPI) r_cnt_spi  <= r_cnt_spi + 8'd1;
        else                  r_cnt_uart <= r_cnt_uart + 8'd1;
      end
    end
  end

  assign mul_a    = r_a;
  assign mul_b    = r_b;
  assign res_data = r_res;
  assign res_tag  = r_tag;
  assign res_err  = r_err;
  assign cnt_uart = r_cnt_uart;
  assign cnt_spi  = r_cnt_spi;

endmodule : mul_req_arbiter

`default_nettype wire
